// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
//
// Purpose: FSM state enum, register/XLEN constants and the stage-control
//          bundle used by pipeline_ctrl.
// Ports:   none (package).
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         XLEN     = 32;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } stage_ctrl_t;

  // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
  localparam stage_ctrl_t CTRL_NORMAL   = 7'b1_1_0_1_0_1_1;
  localparam stage_ctrl_t CTRL_RESET    = 7'b1_1_1_1_1_1_1;
  localparam stage_ctrl_t CTRL_FREEZE   = 7'b0_0_0_0_0_0_0;
  localparam stage_ctrl_t CTRL_REDIRECT = 7'b1_1_1_1_1_1_1;
  // The load moves on to MEM while IF/ID and the PC hold; ID/EX takes a bubble.
  localparam stage_ctrl_t CTRL_LOADUSE  = 7'b0_0_0_1_1_1_1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts cycles where inc=1, sticking at all-ones.
// Ports:   clk   - clock
//          clr   - synchronous clear (takes priority over inc)
//          inc   - increment request
//          count - current count value [W-1:0]
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
//
// Purpose: inserts a load-use bubble, squashes IF/ID and ID/EX on a taken
//          branch resolved in EXU, freezes the whole pipe while MEM waits on
//          the data-memory handshake (with a sticky timeout error), and keeps
//          saturating stall/flush counters.
// Ports:   cpu_clk, cpu_rst                 - clock, sync active-high reset
//          IDU_*                            - decode-stage operand usage
//          EXU_*                            - execute-stage dest/load/branch info
//          MEM_valid, MEM_mem_req           - MEM-stage data access
//          dmem_ready                       - data memory completes this cycle
//          pc_en, *_en, *_flush             - stage register controls
//          redirect_valid, redirect_pc      - PC redirect
//          load_use_stall                   - bubble inserted this cycle
//          bus_err                          - sticky MEM timeout
//          stall_cnt, flush_cnt             - saturating performance counters
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             IDU_valid,
  input  logic [4:0]       IDU_rs1,
  input  logic [4:0]       IDU_rs2,
  input  logic             IDU_rs1_used,
  input  logic             IDU_rs2_used,
  input  logic             EXU_valid,
  input  logic [4:0]       EXU_rd,
  input  logic             EXU_R_Wen,
  input  logic             EXU_mem_ren,
  input  logic             EXU_br_taken,
  input  logic [XLEN-1:0]  EXU_br_target,
  input  logic             MEM_valid,
  input  logic             MEM_mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             load_use_stall,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Timer only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e      state_q,   state_d;
  logic [TMR_W-1:0] timer_q,   timer_d;
  logic             bus_err_q, bus_err_d;

  logic        mem_stall;
  logic        load_use;
  logic        redirect;
  logic        freeze;
  stage_ctrl_t ctrl;

  // ---------------- hazard terms ----------------
  assign mem_stall = MEM_valid & MEM_mem_req & ~dmem_ready;

  assign load_use = EXU_valid & EXU_mem_ren & EXU_R_Wen & (EXU_rd != REG_ZERO) & IDU_valid &
                    ((IDU_rs1_used & (IDU_rs1 == EXU_rd)) |
                     (IDU_rs2_used & (IDU_rs2 == EXU_rd)));

  assign redirect = EXU_valid & EXU_br_taken;

  // ERR freezes unconditionally; otherwise freeze tracks mem_stall directly
  // so release happens in the same cycle dmem_ready rises.
  assign freeze = (state_q == ERR) | mem_stall;

  // ---------------- state register ----------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= RUN;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bus_err_q <= bus_err_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          timer_d = TMR_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  // ---------------- output logic ----------------
  // Priority: reset > freeze > redirect > load-use > normal. A held redirect
  // or load-use simply re-evaluates once the freeze lifts.
  always_comb begin
    ctrl           = CTRL_NORMAL;
    redirect_valid = 1'b0;
    load_use_stall = 1'b0;
    if (cpu_rst) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (redirect) begin
      ctrl           = CTRL_REDIRECT;
      redirect_valid = 1'b1;
    end else if (load_use) begin
      ctrl           = CTRL_LOADUSE;
      load_use_stall = 1'b1;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign redirect_pc = EXU_br_target;
  assign bus_err     = bus_err_q;

  // ---------------- performance counters ----------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (cpu_clk),
    .clr   (cpu_rst),
    .inc   (~pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (cpu_clk),
    .clr   (cpu_rst),
    .inc   (redirect_valid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int TIMEOUT_CYCLES = 4;
  localparam int CNT_W          = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, redirect_valid, load_use_stall}
  localparam logic [8:0] EXP_RESET  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] EXP_NORMAL = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] EXP_LU     = 9'b0_0_0_1_1_1_1_0_1;
  localparam logic [8:0] EXP_REDIR  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] EXP_FREEZE = 9'b0_0_0_0_0_0_0_0_0;

  logic             cpu_clk;
  logic             cpu_rst;
  logic             IDU_valid;
  logic [4:0]       IDU_rs1;
  logic [4:0]       IDU_rs2;
  logic             IDU_rs1_used;
  logic             IDU_rs2_used;
  logic             EXU_valid;
  logic [4:0]       EXU_rd;
  logic             EXU_R_Wen;
  logic             EXU_mem_ren;
  logic             EXU_br_taken;
  logic [31:0]      EXU_br_target;
  logic             MEM_valid;
  logic             MEM_mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             load_use_stall;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_vec;
  int n_bad;

  pipeline_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .IDU_valid      (IDU_valid),
    .IDU_rs1        (IDU_rs1),
    .IDU_rs2        (IDU_rs2),
    .IDU_rs1_used   (IDU_rs1_used),
    .IDU_rs2_used   (IDU_rs2_used),
    .EXU_valid      (EXU_valid),
    .EXU_rd         (EXU_rd),
    .EXU_R_Wen      (EXU_R_Wen),
    .EXU_mem_ren    (EXU_mem_ren),
    .EXU_br_taken   (EXU_br_taken),
    .EXU_br_target  (EXU_br_target),
    .MEM_valid      (MEM_valid),
    .MEM_mem_req    (MEM_mem_req),
    .dmem_ready     (dmem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_use_stall (load_use_stall),
    .bus_err        (bus_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {23'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, memwb_en, redirect_valid, load_use_stall};
  endfunction

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after it.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    IDU_valid = 0; IDU_rs1 = 0; IDU_rs2 = 0; IDU_rs1_used = 0; IDU_rs2_used = 0;
    EXU_valid = 0; EXU_rd = 0; EXU_R_Wen = 0; EXU_mem_ren = 0;
    EXU_br_taken = 0; EXU_br_target = 0;
    MEM_valid = 0; MEM_mem_req = 0; dmem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2);
    EXU_valid = 1; EXU_rd = rd; EXU_R_Wen = 1; EXU_mem_ren = 1;
    IDU_valid = 1; IDU_rs1 = rs1; IDU_rs2 = rs2; IDU_rs1_used = u1; IDU_rs2_used = u2;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle_inputs();
    cpu_rst = 1;
    tick();
    tick();

    // Reset state
    check_value("rst_ctl", ctl(), {23'd0, EXP_RESET});
    check_value("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_value("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check_value("rst_bus_err", 32'(bus_err), 32'd0);

    cpu_rst = 0;
    #1;
    check_value("idle_ctl", ctl(), {23'd0, EXP_NORMAL});

    // Load-use on rs1: one bubble, then normal
    set_load_use(5'd5, 5'd5, 5'd7, 1, 1);
    #1;
    check_value("lu_rs1_ctl", ctl(), {23'd0, EXP_LU});
    tick();
    idle_inputs();
    #1;
    check_value("lu_after_ctl", ctl(), {23'd0, EXP_NORMAL});
    check_value("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load-use via rs2
    set_load_use(5'd9, 5'd3, 5'd9, 1, 1);
    #1;
    check_value("lu_rs2_ctl", ctl(), {23'd0, EXP_LU});
    tick();
    idle_inputs();

    // Non-hazards: x0, unused operand, invalid IDU, no register write
    set_load_use(5'd0, 5'd0, 5'd0, 1, 1);
    #1;
    check_value("x0_ctl", ctl(), {23'd0, EXP_NORMAL});
    set_load_use(5'd5, 5'd5, 5'd6, 0, 1);
    #1;
    check_value("rs1_unused_ctl", ctl(), {23'd0, EXP_NORMAL});
    set_load_use(5'd5, 5'd5, 5'd5, 1, 1);
    IDU_valid = 0;
    #1;
    check_value("idu_inv_ctl", ctl(), {23'd0, EXP_NORMAL});
    set_load_use(5'd5, 5'd5, 5'd5, 1, 1);
    EXU_R_Wen = 0;
    #1;
    check_value("no_wen_ctl", ctl(), {23'd0, EXP_NORMAL});
    tick();
    idle_inputs();
    check_value("nohaz_stall_cnt", 32'(stall_cnt), 32'd2);

    // Redirect overrides a simultaneous load-use
    set_load_use(5'd5, 5'd5, 5'd0, 1, 0);
    EXU_br_taken = 1;
    EXU_br_target = 32'h0000_0100;
    #1;
    check_value("redir_ctl", ctl(), {23'd0, EXP_REDIR});
    check_value("redir_pc", redirect_pc, 32'h0000_0100);
    tick();
    idle_inputs();
    check_value("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    check_value("redir_stall_cnt", 32'(stall_cnt), 32'd2);

    // MEM wait: three frozen cycles, release the cycle dmem_ready rises
    MEM_valid = 1; MEM_mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_value($sformatf("wait_ctl_%0d", i), ctl(), {23'd0, EXP_FREEZE});
      tick();
    end
    dmem_ready = 1;
    #1;
    check_value("wait_rel_ctl", ctl(), {23'd0, EXP_NORMAL});
    tick();
    idle_inputs();
    check_value("wait_state_run", 32'(dut.state_q), 32'd0);
    check_value("wait_stall_cnt", 32'(stall_cnt), 32'd5);

    // Branch held during a MEM wait, applied at release
    MEM_valid = 1; MEM_mem_req = 1; dmem_ready = 0;
    EXU_valid = 1; EXU_br_taken = 1; EXU_br_target = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_value($sformatf("brw_ctl_%0d", i), ctl(), {23'd0, EXP_FREEZE});
      tick();
    end
    dmem_ready = 1;
    #1;
    check_value("brw_rel_ctl", ctl(), {23'd0, EXP_REDIR});
    check_value("brw_rel_pc", redirect_pc, 32'h0000_0200);
    tick();
    idle_inputs();
    check_value("brw_flush_cnt", 32'(flush_cnt), 32'd2);
    check_value("brw_stall_cnt", 32'(stall_cnt), 32'd7);

    // Timeout: bus_err after TIMEOUT_CYCLES wait cycles, ERR freezes for good
    MEM_valid = 1; MEM_mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    check_value("to_pre_bus_err", 32'(bus_err), 32'd0);
    tick();
    check_value("to_bus_err", 32'(bus_err), 32'd1);
    check_value("to_stall_cnt", 32'(stall_cnt), 32'd11);
    idle_inputs();
    dmem_ready = 1;
    #1;
    check_value("err_ctl", ctl(), {23'd0, EXP_FREEZE});
    for (int i = 0; i < 10; i++) tick();
    check_value("err_ctl_late", ctl(), {23'd0, EXP_FREEZE});
    check_value("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Reset clears ERR and counters
    cpu_rst = 1;
    #1;
    check_value("rst2_ctl", ctl(), {23'd0, EXP_RESET});
    tick();
    check_value("rst2_bus_err", 32'(bus_err), 32'd0);
    check_value("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    check_value("rst2_flush_cnt", 32'(flush_cnt), 32'd0);
    cpu_rst = 0;
    idle_inputs();
    #1;
    check_value("rst2_run_ctl", ctl(), {23'd0, EXP_NORMAL});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IFU/IDU/EXU/MEM/WB). It pairs with the forwarding-select unit.
- Detects the load-use hazard that forwarding cannot cover (load in EXU, consumer in IDU) and inserts one bubble.
- Squashes younger stages on a taken branch/jump resolved in EXU.
- Freezes the whole pipeline while a data-memory access in MEM waits for its handshake, with a timeout into a sticky error state.
- Keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive MEM wait cycles before bus error (>=2)
CNT_W, 32, width of performance counters

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  synchronous active-high reset
IDU_valid  in  1  IDU holds a valid instruction
IDU_rs1  in  5  IDU source register 1
IDU_rs2  in  5  IDU source register 2
IDU_rs1_used  in  1  instruction reads rs1
IDU_rs2_used  in  1  instruction reads rs2
EXU_valid  in  1  EXU holds a valid instruction
EXU_rd  in  5  EXU destination register
EXU_R_Wen  in  1  EXU writes a register
EXU_mem_ren  in  1  EXU instruction is a load
EXU_br_taken  in  1  EXU resolved taken branch/jal/jalr
EXU_br_target  in  32  redirect target
MEM_valid  in  1  MEM holds a valid instruction
MEM_mem_req  in  1  MEM instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a bubble
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads a bubble
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
redirect_valid  out  1  PC takes redirect_pc
redirect_pc  out  32  redirect target
load_use_stall  out  1  load-use bubble inserted this cycle
bus_err  out  1  sticky data-memory timeout
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset (cpu_rst=1 at posedge):
  - Registered state: FSM=RUN, wait timer=0, bus_err=0, stall_cnt=0, flush_cnt=0.
  - Outputs while cpu_rst is high: all *_en=1, ifid_flush=idex_flush=1, redirect_valid=0, load_use_stall=0.
  - Reset mid-wait or in ERR returns to RUN on the next edge.
- Hazard terms (combinational):
  - mem_stall = MEM_valid & MEM_mem_req & ~dmem_ready.
  - load_use = EXU_valid & EXU_mem_ren & EXU_R_Wen & (EXU_rd!=0) & IDU_valid & ((IDU_rs1_used & IDU_rs1==EXU_rd) | (IDU_rs2_used & IDU_rs2==EXU_rd)).
  - redirect = EXU_valid & EXU_br_taken.
- FSM states: RUN, MEM_WAIT, ERR.
- Stage-control priority, evaluated each cycle, all combinational from state and inputs:
  1. Freeze. Applies if state=ERR, or mem_stall in RUN/MEM_WAIT.
     - All *_en=0, flushes=0, redirect_valid=0, load_use_stall=0.
     - A pending redirect or load-use stays held in EXU and is applied after the freeze ends.
  2. Redirect. pc_en=1, redirect_valid=1, redirect_pc=EXU_br_target, ifid_flush=1, idex_flush=1, all other en=1.
     - Overrides load_use; load_use_stall=0.
  3. Load-use. pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1, load_use_stall=1.
     - Exactly 1 bubble, because the load advances to MEM. MEM forwarding then supplies the loaded data.
  4. Normal. All *_en=1, flushes=0.
- FSM transitions:
  - RUN: if mem_stall, go to MEM_WAIT with timer=1.
  - MEM_WAIT:
    - If dmem_ready, go to RUN with timer=0. The freeze releases in that same cycle and normal priority applies.
    - Else if timer==TIMEOUT_CYCLES-1, go to ERR and set bus_err=1.
    - Else timer+1.
  - ERR: terminal until reset.
- Latency:
  - Load-use: 1 cycle.
  - Freeze: 0-cycle response to mem_stall; release the same cycle dmem_ready=1.
- Counters:
  - stall_cnt +1 on every non-reset cycle with pc_en=0.
  - flush_cnt +1 on every cycle with redirect_valid=1.
  - Both saturate at all-ones.
- x0 never causes a load-use stall. Invalid EXU/IDU/MEM slots never cause any action.

Decomposition:
- Shared package pipe_pkg:
  - Enum ctrl_state_e {RUN, MEM_WAIT, ERR}.
  - Constants REG_ZERO=5'd0, XLEN=32.
  - Struct stage_ctrl_t bundling the en/flush outputs.
- One sub-module: sat_counter (parameter W, inputs inc/clr, saturating), instantiated twice.

Test Plan:
- EXU: lw x5 (EXU_rd=5, mem_ren=1), IDU: add rs1=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, load_use_stall=1; next cycle all en=1; stall_cnt=1.
- Same as above but EXU_rd=0, or rs1_used=0 -> no stall, all en=1.
- EXU_br_taken=1, target=0x0000_0100, with a simultaneous load-use -> redirect_valid=1, redirect_pc=0x100, ifid_flush=idex_flush=1, load_use_stall=0, flush_cnt=1.
- MEM_mem_req=1, dmem_ready low for 3 cycles then high -> all en=0 for 3 cycles, en=1 on the 4th, FSM back in RUN, stall_cnt=3.
- TIMEOUT_CYCLES=4, dmem_ready held low -> bus_err=1 after 4 wait cycles, en stays 0 indefinitely; pulse cpu_rst -> bus_err=0, counters 0, en=1.
- Branch taken in EXU during a MEM wait -> no redirect while frozen; redirect asserts in the cycle dmem_ready=1.
